// File: rtl/mbinit_sb_pkg.sv
// Shared definitions for the MBINIT sideband TX path: message codes,
// arbiter state encoding and default field widths.
package mbinit_sb_pkg;

  localparam int SB_MSG_W  = 4;
  localparam int SB_INFO_W = 3;

  localparam logic [3:0] SB_REPAIRMB_START_REQ          = 4'b0001;
  localparam logic [3:0] SB_REPAIRMB_START_RESP         = 4'b0010;
  localparam logic [3:0] SB_REPAIRMB_END_REQ            = 4'b0011;
  localparam logic [3:0] SB_REPAIRMB_END_RESP           = 4'b0100;
  localparam logic [3:0] SB_REPAIRMB_APPLY_DEGRADE_REQ  = 4'b0101;
  localparam logic [3:0] SB_REPAIRMB_APPLY_DEGRADE_RESP = 4'b0110;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LAUNCH    = 2'd1,
    ARB_WAIT_RISE = 2'd2,
    ARB_WAIT_FALL = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mbinit_sb_tx_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around the request vector.
module rr_priority_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;

  // Rotate so that bit 0 of rot is the requester at ptr.
  assign rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/mbinit_sb_tx_arbiter.sv
// Round-robin owner of the sideband TX: launches one message at a time and
// reports accept/done/error back to the requesting MBINIT engine.
module mbinit_sb_tx_arbiter
  import mbinit_sb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int MSG_W   = SB_MSG_W,
  parameter  int INFO_W  = SB_INFO_W,
  parameter  int TIMEOUT = 255,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*MSG_W-1:0]  i_req_msg,
  input  logic [NUM_REQ*INFO_W-1:0] i_req_info,
  input  logic                      i_Busy_SideBand,
  output logic [NUM_REQ-1:0]        o_req_accept,
  output logic [NUM_REQ-1:0]        o_req_done,
  output logic [NUM_REQ-1:0]        o_req_error,
  output logic [MSG_W-1:0]          o_TX_SbMessage,
  output logic [INFO_W-1:0]         o_msg_info,
  output logic                      o_ValidOut,
  output logic [IDX_W-1:0]          o_grant_id,
  output logic                      o_arb_busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, grant_id, pick_idx;
  logic [NUM_REQ-1:0] pick_oh, grant_oh;
  logic               pick_any, grant_en, launch, timeout, fall_hit;
  logic               busy_d, done_q;
  logic [MSG_W-1:0]   msg_q, pick_msg;
  logic [INFO_W-1:0]  info_q, pick_info;
  logic [CNT_W-1:0]   cnt;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (i_req_valid),
    .ptr   (rr_ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_msg  = '0;
    pick_info = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_oh[k]) begin
        pick_msg  = pick_msg  | i_req_msg[k*MSG_W +: MSG_W];
        pick_info = pick_info | i_req_info[k*INFO_W +: INFO_W];
      end
    end
  end

  // The IDLE cycle carrying the done pulse is not a grant slot, so a new
  // launch trails done by two cycles.
  assign grant_en = (state == ARB_IDLE) && pick_any && !i_Busy_SideBand &&
                    !i_flush && !done_q;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    timeout   = 1'b0;
    fall_hit  = 1'b0;
    if (i_flush) begin
      state_nxt = ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE:   if (grant_en) state_nxt = ARB_LAUNCH;
        ARB_LAUNCH: begin
          launch    = 1'b1;
          state_nxt = ARB_WAIT_RISE;
        end
        ARB_WAIT_RISE: begin
          if (i_Busy_SideBand) begin
            state_nxt = ARB_WAIT_FALL;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            timeout   = 1'b1;
            state_nxt = ARB_IDLE;
          end
        end
        ARB_WAIT_FALL: begin
          if (busy_d && !i_Busy_SideBand) begin
            fall_hit  = 1'b1;
            state_nxt = ARB_IDLE;
          end
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      msg_q    <= '0;
      info_q   <= '0;
      cnt      <= '0;
      busy_d   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_d <= i_Busy_SideBand;
      done_q <= fall_hit;
      if (grant_en) begin
        grant_id <= pick_idx;
        msg_q    <= pick_msg;
        info_q   <= pick_info;
      end
      if (state == ARB_LAUNCH)
        cnt <= '0;
      else if (state == ARB_WAIT_RISE && !i_Busy_SideBand && cnt != CNT_W'(TIMEOUT))
        cnt <= cnt + 1'b1;
      if (timeout || fall_hit)
        rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  assign grant_oh       = NUM_REQ'(1) << grant_id;
  assign o_ValidOut     = launch;
  assign o_req_accept   = launch ? grant_oh : '0;
  assign o_req_error    = timeout ? grant_oh : '0;
  assign o_req_done     = (done_q && !i_flush) ? grant_oh : '0;
  assign o_TX_SbMessage = msg_q;
  assign o_msg_info     = info_q;
  assign o_grant_id     = grant_id;
  assign o_arb_busy     = (state != ARB_IDLE);

endmodule

// File: doc/mbinit_sb_tx_arbiter.md
# mbinit_sb_tx_arbiter

Shares the single sideband message transmitter between the MBINIT substate engines. These include the REPAIRMB initiator path, the REPAIRMB responder path and the other MBINIT substates. Each engine raises a level request carrying a 4-bit message code and 3-bit message info. The arbiter grants requests round-robin, drives one valid pulse into the sideband TX, tracks the sideband busy handshake, and returns a per-requester completion pulse in place of a local falling-edge-busy detector.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MSG_W, 4, sideband message code width
- INFO_W, 3, message info width
- TIMEOUT, 255, max cycles from launch to busy rise before error (≥2)
- CLK  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_flush  in  1  abort everything (LTSM leaving MBINIT); level
- i_req_valid  in  NUM_REQ  per-requester request, held until accept
- i_req_msg  in  NUM_REQ*MSG_W  message code, requester k at bits [k*MSG_W +: MSG_W]
- i_req_info  in  NUM_REQ*INFO_W  message info, same packing
- i_Busy_SideBand  in  1  sideband TX busy
- o_req_accept  out  NUM_REQ  one-hot 1-cycle pulse: request latched and launched
- o_req_done  out  NUM_REQ  one-hot 1-cycle pulse: message fully sent (busy fell)
- o_req_error  out  NUM_REQ  one-hot 1-cycle pulse: busy never rose within TIMEOUT
- o_TX_SbMessage  out  MSG_W  message to sideband TX
- o_msg_info  out  INFO_W  info to sideband TX
- o_ValidOut  out  1  1-cycle launch strobe to sideband TX
- o_grant_id  out  clog2(NUM_REQ)  current/last granted index
- o_arb_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LAUNCH, WAIT_RISE, WAIT_FALL.
- IDLE: if any i_req_valid and !i_Busy_SideBand, the picker selects the winner and the FSM goes to LAUNCH. The winner is the first set bit at or after rr_ptr, wrapping. The winner's msg and info are registered.
- LAUNCH (1 cycle): o_ValidOut=1, o_TX_SbMessage/o_msg_info = latched values, o_req_accept[g]=1 → WAIT_RISE. Timeout counter cleared.
- WAIT_RISE: i_Busy_SideBand=1 → WAIT_FALL. Otherwise increment counter. At counter==TIMEOUT: o_req_error[g]=1, go to IDLE, rr_ptr=g+1.
- WAIT_FALL: on a busy falling edge (busy_d & !busy): o_req_done[g]=1, go to IDLE, rr_ptr=g+1 mod NUM_REQ.
- o_TX_SbMessage/o_msg_info hold their value outside LAUNCH. o_ValidOut is the only strobe.
- i_flush (any state) → IDLE next cycle. No accept/done/error pulse is issued. rr_ptr is unchanged. While i_flush=1, IDLE grants nothing.
- Requests may drop before accept; only the value sampled in the IDLE grant cycle matters.
- A requester whose valid is still high after accept is treated as a new request.

## Timing
- Reset: state IDLE, rr_ptr=0, counter=0, busy_d=0. All outputs 0, o_grant_id=0.
- Request in IDLE with busy low at cycle n → o_ValidOut and o_req_accept at cycle n+1.
- o_req_done asserts the cycle after busy is first sampled low in WAIT_FALL, registered.
- Earliest re-grant: the IDLE cycle after done/error, so the next o_ValidOut comes 2 cycles after done.
- Busy already high in IDLE (partner traffic) blocks grant; no counter runs.
- Busy rising and falling between two samples is not detectable; the sideband holds busy ≥1 cycle.
- A busy fall in the same cycle as TIMEOUT expiry is impossible: expiry only happens in WAIT_RISE.
- Simultaneous i_flush and busy fall: flush wins, no done.
- Async reset mid-transfer: immediate return to reset values. No pulses are issued.

## Structure
- Package mbinit_sb_pkg holds:
  - sideband message localparams: REPAIRMB start_req 0001, start_resp 0010, end_req 0011, end_resp 0100, apply_degrade_req 0101, apply_degrade_resp 0110;
  - the arbiter state encoding;
  - MSG_W/INFO_W defaults.
- Sub-module rr_priority_picker: combinational. Takes request vector and rr_ptr; outputs one-hot winner, index and any_req.

## Test plan
- Single request: req[1]=1, msg 0001, info 010, busy low. Expect ValidOut at +1 with msg 0001/info 010 and accept[1] pulse. Busy high for 5 cycles then low → done[1] one cycle after busy falls.
- Contention: req[0..3] all high and held. Grant order 0,1,2,3,0 with exactly one ValidOut per grant, none while busy high.
- Pre-busy: busy=1 before any request, req[2]=1. No ValidOut until busy low, then launch at +1.
- Timeout: TIMEOUT=8, busy never rises after launch. Expect error[g] at cycle launch+9, then IDLE, rr_ptr=g+1, no done.
- Flush in WAIT_FALL with a simultaneous busy fall. Expect IDLE next cycle, no done, and no grant while flush is high.
- Async reset asserted during WAIT_RISE. All outputs 0 immediately; after release, req[3] wins first-come from rr_ptr=0.
